// File: rtl/id_ctrl_stage.sv
// Registered decode/control stage: decodes the IF/ID instruction into the EX control bundle and
// inserts load-use bubbles. Define ID_UTYPE_EN to decode lui/auipc; otherwise they are illegal.
module id_ctrl_stage #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            ALUSrc,
  output logic            Branch,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      Jump,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
`ifdef ID_UTYPE_EN
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
`endif

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [2:0]      imm_src;
    logic            alu_src;
    logic            mem_write;
    logic            mem_read;
    logic [1:0]      result_src;
    logic            branch;
    logic [1:0]      alu_op;
    logic [1:0]      jump;
    logic            ill;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } bundle_t;

  bundle_t    dec, out_d, out_q;
  logic       use_rs1, use_rs2;
  logic       adv, hazard, xfer;
  logic [4:0] ld_rd_d, ld_rd_q;
  logic [1:0] cnt_d, cnt_q;

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (in_instr[6:0])
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.result_src = 2'b01;
        use_rs1        = 1'b1;
      end
      OpStore: begin
        dec.imm_src   = 3'b001;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpReg: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpBranch: begin
        dec.imm_src = 3'b010;
        dec.branch  = 1'b1;
        dec.alu_op  = 2'b01;
        dec.jump    = 2'b01;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OpImm: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
        use_rs1       = 1'b1;
      end
      OpJal: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b011;
        dec.result_src = 2'b10;
        dec.jump       = 2'b01;
      end
      OpJalr: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 2'b10;
        use_rs1        = 1'b1;
      end
`ifdef ID_UTYPE_EN
      OpLui: begin
        dec.reg_write = 1'b1;
        dec.imm_src   = 3'b100;
        dec.alu_src   = 1'b1;
      end
      OpAuipc: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b100;
        dec.result_src = 2'b11;
      end
`endif
      default: dec.ill = 1'b1;
    endcase
    dec.valid = 1'b1;
    dec.rs1   = use_rs1 ? in_instr[19:15] : 5'd0;
    dec.rs2   = use_rs2 ? in_instr[24:20] : 5'd0;
    dec.rd    = dec.reg_write ? in_instr[11:7] : 5'd0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
  end

  // Unused sources are already zeroed, so they never match a non-zero ld_rd.
  assign hazard   = in_valid && (cnt_q != 2'd0) && (ld_rd_q != 5'd0) &&
                    ((dec.rs1 == ld_rd_q) || (dec.rs2 == ld_rd_q));
  assign adv      = !out_q.valid || out_ready;
  assign in_ready = adv && !flush && !hazard;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_d   = out_q;
    cnt_d   = cnt_q;
    ld_rd_d = ld_rd_q;
    if (flush) begin
      out_d = '0;
      cnt_d = 2'd0;
    end else if (adv) begin
      out_d = xfer ? dec : '0;
      if (xfer && (in_instr[6:0] == OpLoad) && (in_instr[11:7] != 5'd0)) begin
        ld_rd_d = in_instr[11:7];
        cnt_d   = 2'(LOAD_USE_BUBBLES);
      end else if (cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      cnt_q   <= 2'd0;
      ld_rd_q <= 5'd0;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  assign out_valid = out_q.valid;
  assign RegWrite  = out_q.reg_write;
  assign MemWrite  = out_q.mem_write;
  assign MemRead   = out_q.mem_read;
  assign ALUSrc    = out_q.alu_src;
  assign Branch    = out_q.branch;
  assign ImmSrc    = out_q.imm_src;
  assign ALUOp     = out_q.alu_op;
  assign ResultSrc = out_q.result_src;
  assign Jump      = out_q.jump;
  assign out_rs1   = out_q.rs1;
  assign out_rs2   = out_q.rs2;
  assign out_rd    = out_q.rd;
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;
  assign illegal   = out_q.ill;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Scoreboard bench for id_ctrl_stage: a transaction-level model predicts acceptance and the
// decoded bundle; a separate monitor retires DUT outputs against the queued expectations.
module tb_id_ctrl_stage;
  localparam int unsigned XLEN = 32;
  localparam int unsigned LUB  = 2;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, flush, out_ready, out_valid;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_pc;
  logic            RegWrite, MemWrite, MemRead, ALUSrc, Branch, illegal;
  logic [2:0]      ImmSrc;
  logic [1:0]      ALUOp, ResultSrc, Jump;
  logic [4:0]      out_rs1, out_rs2, out_rd;

  always #5 clk = ~clk;

  id_ctrl_stage #(.XLEN(XLEN), .LOAD_USE_BUBBLES(LUB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc),
    .Branch(Branch), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .Jump(Jump),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
    .out_instr(out_instr), .illegal(illegal)
  );

  typedef struct packed {
    logic [13:0] ctl;  // RegWrite,ImmSrc,ALUSrc,MemWrite,MemRead,ResultSrc,Branch,ALUOp,Jump
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  bit         m_valid = 1'b0;
  logic [4:0] m_ld = 5'd0;
  int         m_left = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Decode table as listed for the stage, plus source usage per opcode.
  function automatic void classify(input logic [31:0] ins, output logic [13:0] ctl,
                                   output bit ill, output bit u1, output bit u2);
    ctl = '0; ill = 1'b0; u1 = 1'b0; u2 = 1'b0;
    case (ins[6:0])
      7'b0000011: begin ctl = 14'b1_000_1_0_1_01_0_00_00; u1 = 1; end
      7'b0100011: begin ctl = 14'b0_001_1_1_0_00_0_00_00; u1 = 1; u2 = 1; end
      7'b0110011: begin ctl = 14'b1_000_0_0_0_00_0_10_00; u1 = 1; u2 = 1; end
      7'b1100011: begin ctl = 14'b0_010_0_0_0_00_1_01_01; u1 = 1; u2 = 1; end
      7'b0010011: begin ctl = 14'b1_000_1_0_0_00_0_10_00; u1 = 1; end
      7'b1101111: ctl = 14'b1_011_0_0_0_10_0_00_01;
      7'b1100111: begin ctl = 14'b1_000_1_0_0_10_0_00_10; u1 = 1; end
`ifdef ID_UTYPE_EN
      7'b0110111: ctl = 14'b1_100_1_0_0_00_0_00_00;
      7'b0010111: ctl = 14'b1_100_0_0_0_11_0_00_00;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // One cycle of stimulus; the model decides acceptance and queues the expected bundle.
  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl,
                      input bit rn, output bit dut_rdy);
    logic [13:0] ctl;
    bit ill, u1, u2, adv, dep, exp_rdy;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = $urandom; out_ready = rdy; flush = fl; rst_n = rn;
    #2;
    dut_rdy = in_ready;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    classify(ins, ctl, ill, u1, u2);
    e.ctl = ctl; e.ill = ill;
    e.rs1 = u1 ? ins[19:15] : 5'd0;
    e.rs2 = u2 ? ins[24:20] : 5'd0;
    e.rd = ctl[13] ? ins[11:7] : 5'd0;
    e.pc = in_pc; e.instr = ins;
    adv = !m_valid || rdy;
    dep = v && m_left > 0 && m_ld != 0 &&
          ((u1 && ins[19:15] == m_ld) || (u2 && ins[24:20] == m_ld));
    exp_rdy = adv && !fl && !dep;
    if (rn) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (!rn) begin
      m_valid = 0; m_left = 0; m_ld = 0; sb.delete();
    end else if (fl) begin
      if (m_valid) void'(sb.pop_front());
      m_valid = 0; m_left = 0;
    end else if (adv) begin
      m_valid = v && exp_rdy;
      if (m_valid) sb.push_back(e);
      if (m_valid && ins[6:0] == 7'b0000011 && ins[11:7] != 0) begin
        m_ld = ins[11:7]; m_left = LUB;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  endtask

  // Holds ins valid until the DUT accepts it; returns cycles spent with in_ready low.
  task automatic issue(input logic [31:0] ins, output int stalls);
    bit r;
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, ins, 1, 0, 1, r);
      if (r) return;
      stalls++;
    end
    chk("issue_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [31:0] r_add(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_lw(logic [4:0] rd, logic [4:0] a);
    return {12'd0, a, 3'b010, rd, 7'b0000011};
  endfunction

  // Monitor: retire whatever the DUT presents and is consumed this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("ctl", 64'({RegWrite, ImmSrc, ALUSrc, MemWrite, MemRead, ResultSrc, Branch,
                        ALUOp, Jump}), 64'(e.ctl));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("regs", 64'({out_rs1, out_rs2, out_rd}), 64'({e.rs1, e.rs2, e.rd}));
        chk("pc_instr", {out_pc, out_instr}, {e.pc, e.instr});
      end
    end
  end

  initial begin
    bit r;
    int st;
    logic [6:0] ops [10];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
    step(0, 0, 1, 0, 0, r);
    step(0, 0, 1, 0, 0, r);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_controls", 64'({RegWrite, MemRead, ImmSrc, ResultSrc, out_rd}), 64'(0));
    chk("rst_pc", 64'(out_pc), 64'(0));

    issue(r_add(3, 1, 2), st);
    issue(i_lw(5, 1), st);
    issue(r_add(6, 5, 2), st);
    chk("load_use_stall", 64'(st), 64'(LUB));
    issue(i_lw(5, 1), st);
    issue(r_add(7, 1, 2), st);
    issue(r_add(8, 5, 0), st);
    chk("indep_slot_stall", 64'(st), 64'(LUB - 1));
    issue(r_add(9, 0, 0), st);
    chk("x0_no_stall", 64'(st), 64'(0));

    // Back-pressure with valid input, then release.
    for (int i = 0; i < 3; i++) begin
      step(1, r_add(10, 1, 1), 0, 0, 1, r);
      chk("hold_in_ready", 64'(r), 64'(0));
    end
    issue(r_add(10, 1, 1), st);

    // Flush a held load; the dependent instruction must then issue at once.
    issue(i_lw(5, 2), st);
    step(0, 0, 0, 0, 1, r);
    step(0, 0, 0, 1, 1, r);
    issue(r_add(11, 5, 5), st);
    chk("flush_no_stall", 64'(st), 64'(0));

    // Reset in the middle of a load-use stall.
    issue(i_lw(5, 1), st);
    step(0, 0, 1, 0, 0, r);
    issue(r_add(12, 5, 1), st);
    chk("reset_no_stall", 64'(st), 64'(0));

    issue({20'h12345, 5'd4, 7'b0110111}, st);
    issue({20'h0abcd, 5'd4, 7'b0010111}, st);

    for (int n = 0; n < 4000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
      ins[11:7] = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0, r);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, r);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode control stage for the pipelined RISC-V core. It is the successor to the combinational main decoder: it decodes the opcode into the datapath control bundle and extracts register addresses. It holds the result in an ID/EX pipeline register behind a valid/ready handshake. It also inserts load-use bubbles and honours pipeline flushes. It sits between the IF/ID register and the execute stage.

## Interface
- `XLEN`, 32, PC width.
- `LOAD_USE_BUBBLES`, 1, bubble slots required between a load and a dependent instruction (1..3).
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_valid` in 1, IF/ID holds an instruction.
- `in_ready` out 1, the stage accepts this cycle (combinational).
- `in_instr` in 32, instruction word.
- `in_pc` in XLEN, PC of `in_instr`.
- `flush` in 1, kill the registered instruction and refuse input this cycle.
- `out_ready` in 1, execute consumes `out_*` this cycle.
- `out_valid` out 1, the registered bundle is a real instruction.
- `RegWrite`, `MemWrite`, `MemRead`, `ALUSrc`, `Branch` out 1 each, registered controls.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUOp`, `ResultSrc`, `Jump` out 2 each.
  - `ResultSrc`: 00 ALU, 01 mem, 10 PC+4, 11 PCTarget.
  - `Jump`: 00 PC+4, 01 PCTarget, 10 ALU result.
- `out_rs1`, `out_rs2`, `out_rd` out 5, register addresses; an unused source reads as 0.
- `out_pc` out XLEN, `out_instr` out 32, pass-through.
- `illegal` out 1, the opcode is undecodable; all controls are 0.

## Operation
- `adv = !out_valid | out_ready`. On an `adv` cycle the output register loads the next entry: either an accepted instruction or a bubble (`out_valid=0`).
- `in_ready = adv & !flush & !hazard`. Transfer occurs when `in_valid & in_ready`.
- Decode table, listed as RegWrite, ImmSrc, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp, Jump:
  - lw (0000011): 1, 000, 1, 0, 1, 01, 0, 00, 00
  - sw (0100011): 0, 001, 1, 1, 0, 00, 0, 00, 00
  - R (0110011): 1, 000, 0, 0, 0, 00, 0, 10, 00
  - B (1100011): 0, 010, 0, 0, 0, 00, 1, 01, 01
  - I-ALU (0010011): 1, 000, 1, 0, 0, 00, 0, 10, 00
  - jal (1101111): 1, 011, 0, 0, 0, 10, 0, 00, 01
  - jalr (1100111): 1, 000, 1, 0, 0, 10, 0, 00, 10
  - Any other opcode: all 0, `illegal=1`, `out_valid=1`.
- Source usage:
  - rs1 is used by lw, sw, R, B, I-ALU and jalr.
  - rs2 is used by sw, R and B.
  - An unused source field is output as 0.
  - `out_rd = instr[11:7]` for RegWrite opcodes, otherwise 0.
- Load-use tracking:
  - Registers: `ld_rd` (5 bits) and `cnt` (2 bits).
  - Issuing a load with rd≠0 sets `ld_rd=rd` and `cnt=LOAD_USE_BUBBLES`.
  - Every other `adv` cycle with `cnt>0` decrements `cnt`, whether the slot carries a real instruction or a bubble.
  - `hazard = in_valid & cnt>0 & ld_rd≠0 & (used rs1==ld_rd | used rs2==ld_rd)`.
  - During a hazard on an `adv` cycle, a bubble is loaded.
- Flush has priority over everything:
  - Next cycle `out_valid=0` and `cnt=0`.
  - No input is accepted and `in_instr` is not consumed.
- When `!adv`, all outputs, `cnt` and `ld_rd` hold.

## Timing
- Reset: every output register is 0, including `out_valid` and `illegal`. `cnt=0`, `ld_rd=0`. After reset, `in_ready=1` once `rst_n=1` and `flush=0`.
- Latency: 1 cycle from transfer to `out_valid`.
- Throughput: 1 instruction per cycle with no hazard.
- Stalls:
  - A load followed immediately by a dependent instruction costs `LOAD_USE_BUBBLES` bubble cycles.
  - An independent instruction issued after the load consumes a bubble slot.
- Reset mid-stall clears `cnt`; the dependent instruction is accepted on the first cycle after reset if `out_ready`.
- `flush` together with `out_ready=0` still clears `out_valid`.
- A dependency on x0 never stalls.

## Configuration
- `ID_UTYPE_EN` defined: lui and auipc are decoded.
  - lui (0110111): RegWrite=1, ImmSrc=100, ALUSrc=1, ALUOp=00, ResultSrc=00, `out_rs1=0`; rs1 is unused.
  - auipc (0010111): RegWrite=1, ImmSrc=100, ResultSrc=11; no sources used.
- `ID_UTYPE_EN` undefined: both opcodes are decoded as illegal.

## Test plan
- Reset then `add x3,x1,x2` with `out_ready=1`:
  - Next cycle: `out_valid=1`, RegWrite=1, ALUOp=10, `out_rd=3`, `out_rs1=1`, `out_rs2=2`.
- `lw x5,0(x1)` then `add x6,x5,x2`, `LOAD_USE_BUBBLES=1`:
  - `in_ready=0` for 1 cycle.
  - Output sequence: lw, bubble, add.
  - With `LOAD_USE_BUBBLES=2`: lw, bubble, bubble, add.
- `lw x5` then independent `add x7,x1,x2` then `add x8,x5,x0`:
  - No bubble is inserted; the second add issues directly.
- `out_ready=0` for 3 cycles with valid input:
  - Outputs hold and `in_ready=0`.
  - Release: the held instruction retires, then the new one loads next cycle.
- `flush` while a lw is held and `out_ready=0`:
  - Next cycle `out_valid=0`, `cnt=0`; the following dependent instruction issues with no stall.
- Opcode 0110111:
  - With `ID_UTYPE_EN`: ImmSrc=100, `out_rs1=0`, `illegal=0`.
  - Without `ID_UTYPE_EN`: `illegal=1`, all controls 0.
